// File: rtl/axis_lane_packer_pkg.sv
// Shared widths and lane-mask helper for the 64->256 bit lane packer.
// The mask is sized for the widest supported word; callers cast it down to their lane count.
package axis_lane_packer_pkg;

  localparam int LANE_WIDTH    = 16;
  localparam int DEF_IN_WIDTH  = 64;
  localparam int DEF_OUT_WIDTH = 256;
  localparam int MAX_LANES     = 64;

  typedef logic [MAX_LANES-1:0] lane_mask_t;

  // Ones for every lane covered by the first nbeats input beats.
  function automatic lane_mask_t keep_mask(input int unsigned nbeats,
                                           input int unsigned lanes_per_beat);
    lane_mask_t mask;
    mask = '0;
    for (int unsigned i = 0; i < MAX_LANES; i++) begin
      if (i < nbeats * lanes_per_beat) mask[i] = 1'b1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/axis_pack_slot.sv
// One holding register for a packed word (data, last, keep) with a valid flag.
// A load takes priority over an unload in the same cycle, so the slot never bubbles.
module axis_pack_slot
  import axis_lane_packer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_OUT_WIDTH,
  parameter int KEEP_WIDTH = DEF_OUT_WIDTH / LANE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  unload,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  input  logic [KEEP_WIDTH-1:0] load_keep,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  last,
  output logic [KEEP_WIDTH-1:0] keep
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      last  <= 1'b0;
      keep  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      last  <= load_last;
      keep  <= load_keep;
    end else if (unload) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/axis_lane_packer.sv
// Packs IN_WIDTH DMA beats little-endian into OUT_WIDTH lane words; s_last flushes a
// zero-padded partial word. An output slot plus one pending slot absorb downstream stalls.
module axis_lane_packer
  import axis_lane_packer_pkg::*;
#(
  parameter int IN_WIDTH  = DEF_IN_WIDTH,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             activate,
  input  logic                             s_valid,
  input  logic                             s_last,
  input  logic [IN_WIDTH-1:0]              s_data,
  output logic                             s_ready,
  output logic                             m_valid,
  output logic                             m_last,
  output logic [OUT_WIDTH-1:0]             m_data,
  output logic [OUT_WIDTH/LANE_WIDTH-1:0]  m_keep,
  input  logic                             m_ready,
  output logic [31:0]                      words_out
);

  localparam int RATIO          = OUT_WIDTH / IN_WIDTH;
  localparam int LANES          = OUT_WIDTH / LANE_WIDTH;
  localparam int LANES_PER_BEAT = IN_WIDTH / LANE_WIDTH;
  localparam int IDX_W          = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  logic                 clear;
  logic [IDX_W-1:0]     beat_idx_reg;
  logic [OUT_WIDTH-1:0] pack_reg;
  logic                 s_fire;
  logic                 final_beat;
  logic                 out_free;
  logic                 m_fire;
  logic                 pend_full;
  logic                 pend_load;
  logic                 pend_drain;
  logic                 out_load;
  logic [OUT_WIDTH-1:0] word_data;
  logic [LANES-1:0]     word_keep;
  logic [OUT_WIDTH-1:0] pend_data;
  logic [LANES-1:0]     pend_keep;
  logic                 pend_last;
  logic [OUT_WIDTH-1:0] out_src_data;
  logic [LANES-1:0]     out_src_keep;
  logic                 out_src_last;

  assign clear = rst | ~activate;

  // s_ready depends only on registered state and the control inputs, never on s_valid.
  assign s_ready    = activate & ~rst & ~pend_full;
  assign s_fire     = s_valid & s_ready;
  assign final_beat = s_fire & (s_last | (beat_idx_reg == LAST_IDX));

  assign out_free = ~m_valid | m_ready;
  assign m_fire   = m_valid & m_ready;

  // pend_full blocks s_ready, so a pending drain and a new final beat never coincide.
  assign pend_load  = final_beat & ~out_free;
  assign pend_drain = pend_full & out_free;
  assign out_load   = out_free & (pend_full | final_beat);

  // Beats below the current index come from pack_reg, the current beat from s_data,
  // and everything above is forced to zero so partial words are clean.
  for (genvar gi = 0; gi < RATIO; gi++) begin : g_word
    assign word_data[gi*IN_WIDTH +: IN_WIDTH] =
        (IDX_W'(gi) == beat_idx_reg) ? s_data :
        (IDX_W'(gi) <  beat_idx_reg) ? pack_reg[gi*IN_WIDTH +: IN_WIDTH] :
                                       '0;
  end

  assign word_keep = LANES'(keep_mask(32'(beat_idx_reg) + 32'd1, LANES_PER_BEAT));

  always_ff @(posedge clk) begin
    if (clear) begin
      beat_idx_reg <= '0;
      pack_reg     <= '0;
    end else if (s_fire) begin
      if (final_beat) begin
        beat_idx_reg <= '0;
        pack_reg     <= '0;
      end else begin
        beat_idx_reg <= beat_idx_reg + 1'b1;
        pack_reg[beat_idx_reg*IN_WIDTH +: IN_WIDTH] <= s_data;
      end
    end
  end

  axis_pack_slot #(
    .DATA_WIDTH (OUT_WIDTH),
    .KEEP_WIDTH (LANES)
  ) u_pend (
    .clk       (clk),
    .rst       (clear),
    .load      (pend_load),
    .unload    (pend_drain),
    .load_data (word_data),
    .load_last (s_last),
    .load_keep (word_keep),
    .valid     (pend_full),
    .data      (pend_data),
    .last      (pend_last),
    .keep      (pend_keep)
  );

  assign out_src_data = pend_full ? pend_data : word_data;
  assign out_src_keep = pend_full ? pend_keep : word_keep;
  assign out_src_last = pend_full ? pend_last : s_last;

  axis_pack_slot #(
    .DATA_WIDTH (OUT_WIDTH),
    .KEEP_WIDTH (LANES)
  ) u_out (
    .clk       (clk),
    .rst       (clear),
    .load      (out_load),
    .unload    (m_fire),
    .load_data (out_src_data),
    .load_last (out_src_last),
    .load_keep (out_src_keep),
    .valid     (m_valid),
    .data      (m_data),
    .last      (m_last),
    .keep      (m_keep)
  );

  always_ff @(posedge clk) begin
    if (clear) begin
      words_out <= '0;
    end else if (m_fire) begin
      words_out <= words_out + 32'd1;
    end
  end

endmodule

// File: tb/tb_axis_lane_packer.sv
// Directed bench for axis_lane_packer: word vectors with hand-computed packed results
// and fire cycles, plus sequences for backpressure, clear and reset.
module tb_axis_lane_packer;

  localparam int IW = 64;
  localparam int OW = 256;
  localparam int KW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          activate;
  logic          s_valid;
  logic          s_last;
  logic [IW-1:0] s_data;
  logic          s_ready;
  logic          m_valid;
  logic          m_last;
  logic [OW-1:0] m_data;
  logic [KW-1:0] m_keep;
  logic          m_ready;
  logic [31:0]   words_out;

  always #5 clk = ~clk;

  axis_lane_packer #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
    .clk       (clk),
    .rst       (rst),
    .activate  (activate),
    .s_valid   (s_valid),
    .s_last    (s_last),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .m_valid   (m_valid),
    .m_last    (m_last),
    .m_data    (m_data),
    .m_keep    (m_keep),
    .m_ready   (m_ready),
    .words_out (words_out)
  );

  // One record per packed word: the beats that build it and the word it must produce,
  // with the run cycle (counted from the first driven beat) at which it is handshaken.
  typedef struct {
    int                  nbeats;
    logic [3:0][IW-1:0]  b;
    logic                last;
    logic [OW-1:0]       exp_data;
    logic [KW-1:0]       exp_keep;
    logic                exp_last;
    int                  exp_cyc;
  } vec_t;

  vec_t vecs [9];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  task automatic setv(input int i, input int nb,
                      input logic [IW-1:0] b0, input logic [IW-1:0] b1,
                      input logic [IW-1:0] b2, input logic [IW-1:0] b3,
                      input logic last, input logic [OW-1:0] ed,
                      input logic [KW-1:0] ek, input logic el, input int ec);
    vecs[i].nbeats   = nb;
    vecs[i].b[0]     = b0;
    vecs[i].b[1]     = b1;
    vecs[i].b[2]     = b2;
    vecs[i].b[3]     = b3;
    vecs[i].last     = last;
    vecs[i].exp_data = ed;
    vecs[i].exp_keep = ek;
    vecs[i].exp_last = el;
    vecs[i].exp_cyc  = ec;
  endtask

  // Streams vectors lo..hi; m_ready is held low for the first 'stall' cycles.
  task automatic run(input int lo, input int hi, input int stall,
                     output int acc_at_release, output int stall_cnt);
    logic [IW-1:0] bd [16];
    logic          bl [16];
    logic [OW-1:0] gd [8];
    logic [KW-1:0] gk [8];
    logic          gl [8];
    int            gc [8];
    int            nb = 0;
    int            ng = 0;
    int            bi = 0;
    int            cyc = 0;
    logic          held_v = 1'b0;
    logic [OW-1:0] hd = '0;
    logic [KW-1:0] hk = '0;
    logic          hl = 1'b0;
    for (int v = lo; v <= hi; v++) begin
      for (int k = 0; k < vecs[v].nbeats; k++) begin
        bd[nb] = vecs[v].b[k];
        bl[nb] = vecs[v].last && (k == vecs[v].nbeats - 1);
        nb++;
      end
    end
    acc_at_release = 0;
    stall_cnt      = 0;
    while (ng < hi - lo + 1 && cyc < 60) begin
      @(negedge clk);
      if (held_v) begin
        chk("hold_data", m_data, hd);
        chk("hold_ctl", {m_valid, m_last, m_keep}, {1'b1, hl, hk});
      end
      if (cyc == stall) acc_at_release = bi;
      s_valid = (bi < nb);
      s_data  = (bi < nb) ? bd[bi] : '0;
      s_last  = (bi < nb) ? bl[bi] : 1'b0;
      m_ready = (cyc >= stall);
      #1;
      if (s_valid && !s_ready) stall_cnt++;
      if (s_valid && s_ready) bi++;
      if (m_valid && m_ready && ng < 8) begin
        gd[ng] = m_data;
        gk[ng] = m_keep;
        gl[ng] = m_last;
        gc[ng] = cyc;
        ng++;
      end
      held_v = m_valid && !m_ready;
      hd = m_data;
      hk = m_keep;
      hl = m_last;
      cyc++;
    end
    for (int w = 0; w <= hi - lo; w++) begin
      if (w < ng) begin
        $display("word v%0d: data=%h keep=%h last=%0d cyc=%0d", lo + w, gd[w], gk[w], gl[w], gc[w]);
        chk($sformatf("v%0d_data", lo + w), gd[w], vecs[lo + w].exp_data);
        chk($sformatf("v%0d_keep", lo + w), gk[w], vecs[lo + w].exp_keep);
        chk($sformatf("v%0d_last", lo + w), gl[w], vecs[lo + w].exp_last);
        chk($sformatf("v%0d_cycle", lo + w), gc[w], vecs[lo + w].exp_cyc);
      end else begin
        total_cnt++;
        $display("FAIL v%0d_missing: got no word within 60 cycles, required one", lo + w);
      end
    end
  endtask

  task automatic clear_test(input bit use_rst);
    int acc, st;
    @(negedge clk);
    s_valid = 1'b1; s_last = 1'b0; s_data = 64'hDEAD_0001; m_ready = 1'b1;
    @(negedge clk);
    s_data = 64'hDEAD_0002;
    @(negedge clk);
    s_valid = 1'b0;
    if (use_rst) rst = 1'b1;
    else activate = 1'b0;
    #1 chk("clear_s_ready", s_ready, 0);
    @(negedge clk);
    rst = 1'b0; activate = 1'b1;
    chk("clear_m_valid", m_valid, 0);
    chk("clear_keep", m_keep, 0);
    chk("clear_words_out", words_out, 0);
    run(8, 8, 0, acc, st);
    chk("clear_no_stall", st, 0);
    @(negedge clk);
    chk("clear_words_after", words_out, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, st;
    rst = 1'b1; activate = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0; m_ready = 1'b0;

    setv(0, 4, 64'h1, 64'h2, 64'h3, 64'h4, 1'b0, {64'h4, 64'h3, 64'h2, 64'h1}, 16'hFFFF, 1'b0, 4);
    setv(1, 4, 64'h5, 64'h6, 64'h7, 64'h8, 1'b1, {64'h8, 64'h7, 64'h6, 64'h5}, 16'hFFFF, 1'b1, 8);
    setv(2, 4, 64'h1, 64'h2, 64'h3, 64'h4, 1'b0, {64'h4, 64'h3, 64'h2, 64'h1}, 16'hFFFF, 1'b0, 4);
    setv(3, 2, 64'h5, 64'h6, 64'h0, 64'h0, 1'b1, {64'h0, 64'h0, 64'h6, 64'h5}, 16'h00FF, 1'b1, 6);
    setv(4, 4, 64'h11, 64'h12, 64'h13, 64'h14, 1'b0, {64'h14, 64'h13, 64'h12, 64'h11}, 16'hFFFF, 1'b0, 10);
    setv(5, 4, 64'h15, 64'h16, 64'h17, 64'h18, 1'b0, {64'h18, 64'h17, 64'h16, 64'h15}, 16'hFFFF, 1'b0, 11);
    setv(6, 4, 64'h19, 64'h1A, 64'h1B, 64'h1C, 1'b1, {64'h1C, 64'h1B, 64'h1A, 64'h19}, 16'hFFFF, 1'b1, 15);
    setv(7, 1, 64'hAB, 64'h0, 64'h0, 64'h0, 1'b1, {64'h0, 64'h0, 64'h0, 64'hAB}, 16'h000F, 1'b1, 1);
    setv(8, 4, 64'h21, 64'h22, 64'h23, 64'h24, 1'b1, {64'h24, 64'h23, 64'h22, 64'h21}, 16'hFFFF, 1'b1, 4);

    repeat (3) @(negedge clk);
    chk("reset_s_ready", s_ready, 0);
    chk("reset_m_valid", m_valid, 0);
    chk("reset_m_data", m_data, 0);
    chk("reset_m_keep", m_keep, 0);
    chk("reset_m_last", m_last, 0);
    chk("reset_words_out", words_out, 0);
    rst = 1'b0; activate = 1'b1;
    #1 chk("ready_after_reset", s_ready, 1);

    run(0, 1, 0, acc, st);
    chk("full_no_stall", st, 0);
    @(negedge clk);
    chk("full_words_out", words_out, 2);

    run(2, 3, 0, acc, st);
    chk("partial_no_stall", st, 0);
    @(negedge clk);
    chk("partial_words_out", words_out, 4);

    run(4, 6, 10, acc, st);
    chk("bp_accepted_beats", acc, 8);
    chk("bp_stall_cycles", st, 3);
    @(negedge clk);
    chk("bp_words_out", words_out, 7);

    run(7, 7, 0, acc, st);
    @(negedge clk);
    chk("single_words_out", words_out, 8);

    clear_test(1'b0);
    clear_test(1'b1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
